// File: rtl/iterative_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter: one shift step per clock from a working register.
// Define SHIFT_STEP4_EN to take 4-bit steps while at least four positions remain.
module iterative_shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       shamt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [4:0]       count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // op 2'b11 is reserved and leaves the operand untouched.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       kind,
                                                  input logic [2:0]       amt);
    logic [WIDTH-1:0] r;
    case (kind)
      2'b00:   r = v << amt;
      2'b01:   r = v >> amt;
      2'b10:   r = $signed(v) >>> amt;
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = data_in;
          count_d = shamt;
          op_d    = op;
          state_d = (shamt == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHIFT_STEP4_EN
        if (count_q >= 5'd4) begin
          work_d  = shift_step(work_q, op_q, 3'd4);
          count_d = count_q - 5'd4;
        end else begin
          work_d  = shift_step(work_q, op_q, 3'd1);
          count_d = count_q - 5'd1;
        end
`else
        work_d  = shift_step(work_q, op_q, 3'd1);
        count_d = count_q - 5'd1;
`endif
        if (count_d == 5'd0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Result is captured on the edge that enters DONE, so it is valid alongside done.
    if (state_d == DONE && state_q != DONE) begin
      result_d = work_d;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      count_q  <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: directed table, random vectors
// against an arithmetic reference model, and handshake/reset corner sequences.
module tb_iterative_shift_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp_result;
  } vec_t;

  always #5 clock = ~clock;

  iterative_shift_unit dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .op      (op),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] k, input logic [31:0] d, input logic [4:0] s);
    logic signed [31:0] sd;
    sd = d;
    case (k)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return sd >>> s;
      default: return d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] s);
`ifdef SHIFT_STEP4_EN
    return int'(s) / 4 + int'(s) % 4;
`else
    return int'(s);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Called away from a clock edge with the DUT idle; the next posedge is edge 0.
  task automatic applyStimulus(input logic [1:0] k, input logic [31:0] d, input logic [4:0] s,
                               output logic [31:0] res, output int lat, output int pulses,
                               output bit busy_ok);
    op      = k;
    data_in = d;
    shamt   = s;
    start   = 1'b1;
    lat     = -1;
    pulses  = 0;
    busy_ok = 1'b1;
    res     = 'x;
    for (int e = 0; e < 40; e++) begin
      @(posedge clock);
      #1;
      start   = 1'b0;
      data_in = $urandom;
      shamt   = 5'($urandom_range(0, 31));
      op      = 2'($urandom_range(0, 3));
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = e;
          res = result;
        end
      end
      if (lat < 0 || lat == e) begin
        if (!busy) busy_ok = 1'b0;
      end else if (busy) begin
        busy_ok = 1'b0;
      end
      if (lat >= 0 && e >= lat + 2) break;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [1:0] k, input logic [31:0] d,
                             input logic [4:0] s, input logic [31:0] expected);
    logic [31:0] res;
    int lat, pulses;
    bit busy_ok;
    applyStimulus(k, d, s, res, lat, pulses, busy_ok);
    checkOutput({name, " result"}, res, expected);
    checkOutput({name, " latency"}, lat, ref_latency(s));
    checkOutput({name, " done pulses"}, pulses, 1);
    checkOutput({name, " busy window"}, 32'(busy_ok), 1);
    checkOutput({name, " result held"}, result, expected);
  endtask

  initial begin
    vec_t vecs[7];
    logic [1:0]  rop;
    logic [31:0] rdata;
    logic [4:0]  rsh;
    logic [31:0] res;
    int lat, pulses;
    bit seen;

    vecs[0] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
    vecs[1] = '{2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[2] = '{2'b10, 32'h4000_0000, 5'd4,  32'h0400_0000};
    vecs[3] = '{2'b00, 32'h0000_0001, 5'd0,  32'h0000_0001};
    vecs[4] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[5] = '{2'b11, 32'h1234_5678, 5'd7,  32'h1234_5678};
    vecs[6] = '{2'b10, 32'hF0F0_0000, 5'd31, 32'hFFFF_FFFF};

    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    op      = '0;
    #2;
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset done", 32'(done), 0);
    checkOutput("reset result", result, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("idle busy", 32'(busy), 0);

    for (int i = 0; i < 7; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp_result);
    end

    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom_range(0, 3));
      rdata = $urandom;
      rsh   = 5'($urandom_range(0, 31));
      runAndCheck($sformatf("rand%0d", i), rop, rdata, rsh, ref_shift(rop, rdata, rsh));
    end

    // Second start pulse lands while busy and must be dropped.
    op = 2'b01; data_in = 32'h0000_FF00; shamt = 5'd8; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = -1; pulses = 0; res = 'x;
    for (int e = 1; e <= 20; e++) begin
      if (e == 3) begin
        start = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd8; op = 2'b01;
      end
      @(posedge clock);
      #1 start = 1'b0;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = e;
          res = result;
        end
      end
    end
    checkOutput("busy-start result", res, 32'h0000_00FF);
    checkOutput("busy-start latency", lat, ref_latency(5'd8));
    checkOutput("busy-start pulses", pulses, 1);

    // start held high through DONE: the DONE-cycle sample is ignored.
    op = 2'b00; data_in = 32'h0000_0001; shamt = 5'd2; start = 1'b1;
    seen = 1'b0;
    for (int e = 0; e < 40 && !seen; e++) begin
      @(posedge clock);
      #1;
      if (done) seen = 1'b1;
    end
    checkOutput("hold-start done seen", 32'(seen), 1);
    checkOutput("hold-start result", result, 32'h0000_0004);
    @(posedge clock);
    #1;
    checkOutput("hold-start busy after done", 32'(busy), 0);
    start = 1'b0;
    @(posedge clock);
    #1;

    // Asynchronous reset in the middle of a long shift.
    op = 2'b01; data_in = 32'hA5A5_0000; shamt = 5'd20; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset busy", 32'(busy), 0);
    checkOutput("midreset done", 32'(done), 0);
    checkOutput("midreset result", result, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    runAndCheck("post-reset", 2'b01, 32'h0000_0010, 5'd4, 32'h0000_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_shift_unit.md
Name: iterative_shift_unit

Overview:
- Multi-cycle shifter for the ALU shift path.
- Performs SLL, SRL or SRA on a 32-bit operand by 0..31 positions.
- Applies one single-bit shift step per clock, feeding the single-bit right/left shift stage from a working register.
- Sits between ALU operand decode and the result mux; the ALU holds its result select until done.

Parameters:
- WIDTH, 32, operand width; fixed at 32, shamt width is 5.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- data_in  input  32  operand, captured with start
- shamt  input  5  shift amount, captured with start
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse, result valid
- result  output  32  registered result, held until next done

Behaviour:
- Clock and reset: single clock `clock`; reset `reset` is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, result=0, working reg=0, count=0.
- States and transitions:
  - IDLE: start=1 captures data_in into working reg, shamt into count, op into op_q. If shamt==0 go to DONE, else go to SHIFT.
  - SHIFT: each edge applies one 1-bit shift to the working reg and decrements count. On the edge where count goes from 1 to 0, go to DONE.
  - DONE: result <= working reg; done=1 for exactly this cycle; next edge returns to IDLE.
- Shift fill rules:
  - SLL: out[0]=0, out[i]=reg[i-1].
  - SRL: out[31]=0, out[i]=reg[i+1].
  - SRA: out[31]=reg[31] (sign preserved), out[i]=reg[i+1].
  - op=11: working reg unchanged each step (pass-through). Same latency as the other ops.
- Latency: call the edge that samples start edge 0. done is high during the cycle following edge N, where N=shamt (shamt=0 gives N=0).
- Handshake: start is ignored while busy=1, including in the DONE cycle. Inputs are don't-care after capture.
- Result is registered on entry to DONE and stays stable through IDLE until the next DONE.
- Reset mid-operation: immediate return to reset values. A new start is accepted on the first edge after reset deasserts.
- Shift count never exceeds 31; no modulo or wrap logic is needed.
- Outputs are direct register outputs; no combinational path from start to busy or done.

Optional Feature:
- Macro: SHIFT_STEP4_EN.
- When defined: in SHIFT, if count>=4, apply a 4-bit shift (same fill rules) and subtract 4; otherwise apply a 1-bit step.
  - Latency N = shamt/4 + shamt%4 (integer division).
  - Example: shamt=31 gives N=10.
- When undefined: 1-bit step only, N=shamt.
- Ports and reset values are identical in both builds.

Test Plan:
- SRL, data_in=0x80000000, shamt=31 -> result=0x00000001, done after edge 31 (edge 10 with SHIFT_STEP4_EN), busy high edges 0..31.
- SRA, data_in=0x80000000, shamt=4 -> result=0xF8000000. SRA, data_in=0x40000000, shamt=4 -> result=0x04000000.
- SLL, data_in=0x00000001, shamt=0 -> done in cycle after edge 0, result=0x00000001. SLL, data_in=0x00000001, shamt=31 -> result=0x80000000.
- Start while busy: start SRL 0x0000FF00 by 8, then pulse start with 0xFFFFFFFF at edge 3 -> second request ignored, result=0x000000FF, exactly one done pulse.
- Reset mid-shift: assert reset at edge 5 of a 20-step shift -> busy=0, done=0, result=0 immediately (asynchronous). A new SRL 0x10 by 4 afterwards -> result=0x00000001.
- op=11, data_in=0x12345678, shamt=7 -> result=0x12345678, done after edge 7.
